// File: rtl/core_pkg.sv
// Shared ISA definitions for the 16-bit core: opcodes, instruction field positions,
// and the decoded ID/EX bundle handed from decode to execute.
package core_pkg;

  localparam int WORD_W  = 16;
  localparam int REG_CNT = 16;
  localparam int REG_AW  = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;

  // Instruction field bit positions: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] dest;
    logic [WORD_W-1:0] operand_a;
    logic [WORD_W-1:0] operand_b;
    logic [WORD_W-1:0] store_data;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [WORD_W-1:0] next_pc;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic [WORD_W-1:0] sign_ext_imm4(input logic [3:0] imm);
    return {{(WORD_W-4){imm[3]}}, imm};
  endfunction

  // Opcodes 9..F are reserved and treated exactly like NOP.
  function automatic logic is_valid_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_BEQ);
  endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// 16x16 register file, three combinational read ports and one write port; r0 reads zero.
// DECODE_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module register_file
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] raddr_c,
  output logic [WORD_W-1:0] rdata_a,
  output logic [WORD_W-1:0] rdata_b,
  output logic [WORD_W-1:0] rdata_c,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [WORD_W-1:0] read_port(input logic [REG_AW-1:0] addr);
    logic [WORD_W-1:0] val;
    val = (addr == '0) ? '0 : regs[addr];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_en && (wr_addr == addr) && (addr != '0)) val = wr_data;
`endif
    return val;
  endfunction

  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
    rdata_c = read_port(raddr_c);
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: field decode, operand read, load-use hazard detection and the ID/EX register.
// Optional same-cycle writeback forwarding is enabled by DECODE_WB_BYPASS_EN.
module instruction_decode
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] instruction_if,
  input  logic [WORD_W-1:0] next_program_counter_if,
  input  logic              flush_id,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WORD_W-1:0] wb_data,
  output logic              stall_id,
  output logic [3:0]        opcode_id,
  output logic [REG_AW-1:0] dest_id,
  output logic [WORD_W-1:0] operand_a_id,
  output logic [WORD_W-1:0] operand_b_id,
  output logic [WORD_W-1:0] store_data_id,
  output logic              reg_write_id,
  output logic              mem_read_id,
  output logic              mem_write_id,
  output logic              branch_id,
  output logic [WORD_W-1:0] next_program_counter_id
);

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs, rt;
  logic [WORD_W-1:0] rd_val, rs_val, rt_val;
  logic              uses_rs, uses_rt, uses_rd;
  logic              load_use;
  id_ex_t            decoded, id_ex_d, id_ex_q;

  assign op = instruction_if[OPC_MSB:OPC_LSB];
  assign rd = instruction_if[RD_MSB:RD_LSB];
  assign rs = instruction_if[RS_MSB:RS_LSB];
  assign rt = instruction_if[RT_MSB:RT_LSB];

  register_file u_register_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (rt),
    .raddr_c (rd),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .rdata_c (rd_val),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  always_comb begin
    uses_rs = is_valid_op(op);
    uses_rt = (op >= OP_ADD) && (op <= OP_OR);
    uses_rd = (op == OP_ST) || (op == OP_BEQ);
  end

  // Load-use: the load sitting in ID/EX cannot forward in time, so a dependent
  // instruction is held in fetch for one cycle while a bubble goes downstream.
  always_comb begin
    load_use = id_ex_q.mem_read && (id_ex_q.dest != '0) &&
               ((uses_rs && (rs == id_ex_q.dest)) ||
                (uses_rt && (rt == id_ex_q.dest)) ||
                (uses_rd && (rd == id_ex_q.dest)));
  end

  // Flow control: stall_id high means fetch must hold PC and instruction this
  // cycle; flush_id squashes the instruction in decode and overrides any stall.
  assign stall_id = load_use && !flush_id;

  always_comb begin
    decoded = ID_EX_BUBBLE;
    if (is_valid_op(op)) begin
      decoded.opcode    = op;
      decoded.operand_a = rs_val;
      decoded.operand_b = uses_rt ? rt_val : sign_ext_imm4(rt);
      decoded.next_pc   = next_program_counter_if;
      decoded.reg_write = (op <= OP_LD) && (rd != '0);
      decoded.dest      = (op <= OP_LD) ? rd : '0;
      decoded.mem_read  = (op == OP_LD);
      decoded.mem_write = (op == OP_ST);
      decoded.branch    = (op == OP_BEQ);
      decoded.store_data = uses_rd ? rd_val : '0;
    end
  end

  always_comb begin
    id_ex_d = decoded;
    if (flush_id || load_use) id_ex_d = ID_EX_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_ex_q <= ID_EX_BUBBLE;
    else        id_ex_q <= id_ex_d;
  end

  assign opcode_id               = id_ex_q.opcode;
  assign dest_id                 = id_ex_q.dest;
  assign operand_a_id            = id_ex_q.operand_a;
  assign operand_b_id            = id_ex_q.operand_b;
  assign store_data_id           = id_ex_q.store_data;
  assign reg_write_id            = id_ex_q.reg_write;
  assign mem_read_id             = id_ex_q.mem_read;
  assign mem_write_id            = id_ex_q.mem_write;
  assign branch_id               = id_ex_q.branch;
  assign next_program_counter_id = id_ex_q.next_pc;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode; expected values are hand-derived from the ISA.
// Build with +define+DECODE_WB_BYPASS_EN to check the forwarding variant.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction_if = 16'h0000;
  logic [15:0] next_program_counter_if = 16'h0000;
  logic        flush_id = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = 4'h0;
  logic [15:0] wb_data = 16'h0000;
  logic        stall_id;
  logic [3:0]  opcode_id;
  logic [3:0]  dest_id;
  logic [15:0] operand_a_id;
  logic [15:0] operand_b_id;
  logic [15:0] store_data_id;
  logic        reg_write_id;
  logic        mem_read_id;
  logic        mem_write_id;
  logic        branch_id;
  logic [15:0] next_program_counter_id;

  int checks = 0;
  int passes = 0;

  instruction_decode dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .instruction_if          (instruction_if),
    .next_program_counter_if (next_program_counter_if),
    .flush_id                (flush_id),
    .wb_en                   (wb_en),
    .wb_addr                 (wb_addr),
    .wb_data                 (wb_data),
    .stall_id                (stall_id),
    .opcode_id               (opcode_id),
    .dest_id                 (dest_id),
    .operand_a_id            (operand_a_id),
    .operand_b_id            (operand_b_id),
    .store_data_id           (store_data_id),
    .reg_write_id            (reg_write_id),
    .mem_read_id             (mem_read_id),
    .mem_write_id            (mem_write_id),
    .branch_id               (branch_id),
    .next_program_counter_id (next_program_counter_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] npc);
    instruction_if = instr;
    next_program_counter_if = npc;
    #1;
  endtask

  task automatic wb_write(input logic [3:0] addr, input logic [15:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    instruction_if = 16'h1312;
    #12;
    checks++; if (stall_id !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_id); else passes++;
    checks++; if (opcode_id !== 4'h0 || reg_write_id !== 1'b0 || mem_read_id !== 1'b0)
      $display("FAIL reset_ctrl got=%h/%b/%b exp=0/0/0", opcode_id, reg_write_id, mem_read_id); else passes++;
    checks++; if (operand_a_id !== 16'h0 || next_program_counter_id !== 16'h0)
      $display("FAIL reset_data got=%h/%h exp=0/0", operand_a_id, next_program_counter_id); else passes++;
    rst_n = 1'b1;
    instruction_if = 16'h0000;
    tick();
  endtask

  task automatic test_add();
    wb_write(4'd1, 16'h0005);
    wb_write(4'd2, 16'h0003);
    drive(16'h1312, 16'h0010);
    checks++; if (stall_id !== 1'b0) $display("FAIL add_stall got=%b exp=0", stall_id); else passes++;
    tick();
    checks++; if (opcode_id !== 4'h1 || dest_id !== 4'h3 || reg_write_id !== 1'b1)
      $display("FAIL add_ctrl got=%h/%h/%b exp=1/3/1", opcode_id, dest_id, reg_write_id); else passes++;
    checks++; if (operand_a_id !== 16'h0005 || operand_b_id !== 16'h0003)
      $display("FAIL add_operands got=%h/%h exp=0005/0003", operand_a_id, operand_b_id); else passes++;
    checks++; if (next_program_counter_id !== 16'h0010)
      $display("FAIL add_npc got=%h exp=0010", next_program_counter_id); else passes++;
    drive(16'h1012, 16'h0011);
    tick();
    checks++; if (reg_write_id !== 1'b0) $display("FAIL add_rd0_regwrite got=%b exp=0", reg_write_id); else passes++;
  endtask

  task automatic test_addi();
    drive(16'h541E, 16'h0012);
    tick();
    checks++; if (opcode_id !== 4'h5 || operand_a_id !== 16'h0005 || operand_b_id !== 16'hFFFE)
      $display("FAIL addi got=%h/%h/%h exp=5/0005/FFFE", opcode_id, operand_a_id, operand_b_id); else passes++;
  endtask

  task automatic test_st_beq();
    drive(16'h7211, 16'h0013);
    tick();
    checks++; if (mem_write_id !== 1'b1 || reg_write_id !== 1'b0 || mem_read_id !== 1'b0)
      $display("FAIL st_ctrl got=%b/%b/%b exp=1/0/0", mem_write_id, reg_write_id, mem_read_id); else passes++;
    checks++; if (operand_a_id !== 16'h0005 || operand_b_id !== 16'h0001 || store_data_id !== 16'h0003)
      $display("FAIL st_data got=%h/%h/%h exp=0005/0001/0003", operand_a_id, operand_b_id, store_data_id); else passes++;
    drive(16'h821F, 16'h0014);
    tick();
    checks++; if (branch_id !== 1'b1 || operand_b_id !== 16'hFFFF || store_data_id !== 16'h0003)
      $display("FAIL beq got=%b/%h/%h exp=1/FFFF/0003", branch_id, operand_b_id, store_data_id); else passes++;
    drive(16'hF123, 16'h0015);
    tick();
    checks++; if (opcode_id !== 4'h0 || reg_write_id !== 1'b0 || branch_id !== 1'b0 || mem_write_id !== 1'b0)
      $display("FAIL reserved got=%h/%b/%b/%b exp=0/0/0/0", opcode_id, reg_write_id, branch_id, mem_write_id); else passes++;
  endtask

  task automatic test_load_use();
    int stalls;
    drive(16'h6510, 16'h0020);
    tick();
    checks++; if (mem_read_id !== 1'b1 || dest_id !== 4'h5)
      $display("FAIL ld_ctrl got=%b/%h exp=1/5", mem_read_id, dest_id); else passes++;
    drive(16'h1652, 16'h0021);
    stalls = 0;
    for (int i = 0; i < 4 && opcode_id !== 4'h1; i++) begin
      if (stall_id === 1'b1) stalls++;
      tick();
    end
    checks++; if (stalls != 1) $display("FAIL ld_use_stall_cycles got=%0d exp=1", stalls); else passes++;
    checks++; if (opcode_id !== 4'h1 || dest_id !== 4'h6 || operand_a_id !== 16'h0000 || operand_b_id !== 16'h0003)
      $display("FAIL ld_use_add got=%h/%h/%h/%h exp=1/6/0000/0003", opcode_id, dest_id, operand_a_id, operand_b_id); else passes++;
    checks++; if (stall_id !== 1'b0) $display("FAIL ld_use_after got=%b exp=0", stall_id); else passes++;
    // bubble check: one edge after the stall
    drive(16'h6510, 16'h0022);
    tick();
    drive(16'h1652, 16'h0023);
    tick();
    checks++; if (opcode_id !== 4'h0 || reg_write_id !== 1'b0 || mem_read_id !== 1'b0 || next_program_counter_id !== 16'h0)
      $display("FAIL ld_use_bubble got=%h/%b/%b/%h exp=0/0/0/0000", opcode_id, reg_write_id, mem_read_id, next_program_counter_id); else passes++;
    tick();
    // rd of ST is a source too
    drive(16'h6510, 16'h0024);
    tick();
    drive(16'h7510, 16'h0025);
    checks++; if (stall_id !== 1'b1) $display("FAIL st_rd_hazard got=%b exp=1", stall_id); else passes++;
    tick();
    tick();
    checks++; if (mem_write_id !== 1'b1) $display("FAIL st_after_stall got=%b exp=1", mem_write_id); else passes++;
  endtask

  task automatic test_flush();
    drive(16'h6510, 16'h0030);
    tick();
    flush_id = 1'b1;
    drive(16'h1652, 16'h0031);
    checks++; if (stall_id !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall_id); else passes++;
    tick();
    checks++; if (opcode_id !== 4'h0 || reg_write_id !== 1'b0 || operand_b_id !== 16'h0)
      $display("FAIL flush_bubble got=%h/%b/%h exp=0/0/0000", opcode_id, reg_write_id, operand_b_id); else passes++;
    flush_id = 1'b0;
    drive(16'h0000, 16'h0032);
    tick();
    checks++; if (opcode_id !== 4'h0 || reg_write_id !== 1'b0)
      $display("FAIL flush_no_redecode got=%h/%b exp=0/0", opcode_id, reg_write_id); else passes++;
  endtask

  task automatic test_r0();
    drive(16'h0000, 16'h0040);
    wb_write(4'd0, 16'hBEEF);
    drive(16'h1700, 16'h0041);
    tick();
    checks++; if (operand_a_id !== 16'h0 || operand_b_id !== 16'h0 || dest_id !== 4'h7)
      $display("FAIL r0_read got=%h/%h/%h exp=0000/0000/7", operand_a_id, operand_b_id, dest_id); else passes++;
  endtask

  task automatic test_bypass();
    logic [15:0] exp_a;
`ifdef DECODE_WB_BYPASS_EN
    exp_a = 16'h1234;
`else
    exp_a = 16'h0005;
`endif
    drive(16'h1311, 16'h0050);
    wb_write(4'd1, 16'h1234);
    checks++; if (operand_a_id !== exp_a || operand_b_id !== exp_a)
      $display("FAIL same_cycle_wb got=%h/%h exp=%h", operand_a_id, operand_b_id, exp_a); else passes++;
    tick();
    checks++; if (operand_a_id !== 16'h1234)
      $display("FAIL wb_next_cycle got=%h exp=1234", operand_a_id); else passes++;
  endtask

  task automatic test_reset_mid_stall();
    drive(16'h6510, 16'h0060);
    tick();
    drive(16'h1652, 16'h0061);
    checks++; if (stall_id !== 1'b1) $display("FAIL pre_reset_stall got=%b exp=1", stall_id); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (stall_id !== 1'b0 || mem_read_id !== 1'b0)
      $display("FAIL reset_clears_stall got=%b/%b exp=0/0", stall_id, mem_read_id); else passes++;
    #3;
    rst_n = 1'b1;
    tick();
    checks++; if (opcode_id !== 4'h1 || dest_id !== 4'h6 || operand_b_id !== 16'h0)
      $display("FAIL post_reset_decode got=%h/%h/%h exp=1/6/0000", opcode_id, dest_id, operand_b_id); else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_st_beq();
    test_load_use();
    test_flush();
    test_r0();
    test_bypass();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
